// File: rtl/sram_arbiter_if.sv
// Bus bundle between the on-chip masters and the SRAM arbiter.
// The master side drives per-port requests and the controller's read word.
// The slave side (the arbiter) returns acks, read data and the controller request.
interface sram_arbiter_if;
  // Per-port request side
  logic        cyc;
  logic [3:0]  req;
  logic [83:0] addr;
  logic [63:0] wrdata;
  logic [7:0]  bsel;
  logic [3:0]  rnw;
  logic [3:0]  ack;
  logic [3:0]  rdy;
  logic [15:0] rddata;
  // SRAM controller side
  logic        mem_req;
  logic [20:0] mem_addr;
  logic [15:0] mem_wrdata;
  logic [1:0]  mem_bsel;
  logic        mem_rnw;
  logic [15:0] mem_rddata;

  modport master (
    output cyc, req, addr, wrdata, bsel, rnw, mem_rddata,
    input  ack, rdy, rddata, mem_req, mem_addr, mem_wrdata, mem_bsel, mem_rnw
  );

  modport slave (
    input  cyc, req, addr, wrdata, bsel, rnw, mem_rddata,
    output ack, rdy, rddata, mem_req, mem_addr, mem_wrdata, mem_bsel, mem_rnw
  );
endinterface

// File: rtl/sram_arbiter.sv
// Four-port SRAM arbiter: video (port 0, fixed top priority with a starvation
// limit), CPU/DMA/TS (ports 1-3, round-robin). One grant per memory-cycle
// strobe; ack one clk after the grant, read data returned on the next strobe.
module sram_arbiter #(
  parameter int unsigned STARVE_LIM = 7
) (
  input logic          clk,
  input logic          rst_n,
  sram_arbiter_if.slave bus
);

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_PEND = 1'b1
  } rd_state_t;

  // Round-robin search over ports 1-3 starting at ptr; returns 0 when none request.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
    logic [1:0] p;
    logic       hit;
    rr_pick = 2'd0;
    p       = ptr;
    for (int k = 0; k < 3; k++) begin
      case (p)
        2'd1:    hit = r[0];
        2'd2:    hit = r[1];
        2'd3:    hit = r[2];
        default: hit = 1'b0;
      endcase
      if ((rr_pick == 2'd0) && hit) begin
        rr_pick = p;
      end else begin
        rr_pick = rr_pick;
      end
      p = (p == 2'd3) ? 2'd1 : (p + 2'd1);
    end
  endfunction

  // One-hot port strobe for a 2-bit port number.
  function automatic logic [3:0] port_onehot(input logic [1:0] p);
    port_onehot = 4'b0001 << p;
  endfunction

  // Registered state
  logic [3:0]  ack_q, ack_d;
  logic [3:0]  rdy_q, rdy_d;
  logic [15:0] rddata_q, rddata_d;
  logic [1:0]  rr_q, rr_d;
  logic [3:0]  scnt_q, scnt_d;
  rd_state_t   rd_state_q, rd_state_d;
  logic [1:0]  rd_port_q, rd_port_d;

  // Combinational selection
  logic        force_s;
  logic [1:0]  rr_win_s;
  logic [1:0]  win_s;
  logic        win_vld_s;
  logic [20:0] mem_addr_s;
  logic [15:0] mem_wrdata_s;
  logic [1:0]  mem_bsel_s;
  logic        mem_rnw_s;

  // Pick the winner: port 0 first unless it has hogged STARVE_LIM slots in a row.
  always_comb begin
    force_s   = (scnt_q == LIM) && (|bus.req[3:1]);
    rr_win_s  = rr_pick(bus.req[3:1], rr_q);
    win_vld_s = |bus.req;
    if (bus.req[0] && !force_s) begin
      win_s = 2'd0;
    end else begin
      // With only port 0 requesting, rr_pick yields 0, which is the right winner.
      win_s = rr_win_s;
    end
  end

  // Route the winner's request fields to the controller; idle looks like a read of 0.
  always_comb begin
    mem_addr_s   = 21'd0;
    mem_wrdata_s = 16'd0;
    mem_bsel_s   = 2'd0;
    mem_rnw_s    = 1'b1;
    if (win_vld_s) begin
      case (win_s)
        2'd0: begin
          mem_addr_s   = bus.addr[20:0];
          mem_wrdata_s = bus.wrdata[15:0];
          mem_bsel_s   = bus.bsel[1:0];
          mem_rnw_s    = bus.rnw[0];
        end
        2'd1: begin
          mem_addr_s   = bus.addr[41:21];
          mem_wrdata_s = bus.wrdata[31:16];
          mem_bsel_s   = bus.bsel[3:2];
          mem_rnw_s    = bus.rnw[1];
        end
        2'd2: begin
          mem_addr_s   = bus.addr[62:42];
          mem_wrdata_s = bus.wrdata[47:32];
          mem_bsel_s   = bus.bsel[5:4];
          mem_rnw_s    = bus.rnw[2];
        end
        2'd3: begin
          mem_addr_s   = bus.addr[83:63];
          mem_wrdata_s = bus.wrdata[63:48];
          mem_bsel_s   = bus.bsel[7:6];
          mem_rnw_s    = bus.rnw[3];
        end
        default: begin
          mem_addr_s   = 21'd0;
          mem_wrdata_s = 16'd0;
          mem_bsel_s   = 2'd0;
          mem_rnw_s    = 1'b1;
        end
      endcase
    end else begin
      mem_rnw_s = 1'b1;
    end
  end

  // Next-state logic: everything advances only on a memory-cycle strobe.
  always_comb begin
    ack_d      = 4'd0;
    rdy_d      = 4'd0;
    rddata_d   = rddata_q;
    rr_d       = rr_q;
    scnt_d     = scnt_q;
    rd_state_d = rd_state_q;
    rd_port_d  = rd_port_q;
    if (bus.cyc) begin
      // Return the previous read; this strobe may also issue a new grant.
      case (rd_state_q)
        RD_PEND: begin
          rddata_d = bus.mem_rddata;
          rdy_d    = port_onehot(rd_port_q);
        end
        RD_IDLE: begin
          rdy_d = 4'd0;
        end
        default: begin
          rdy_d = 4'd0;
        end
      endcase

      if (win_vld_s) begin
        ack_d = port_onehot(win_s);
        if (win_s != 2'd0) begin
          rr_d = (win_s == 2'd3) ? 2'd1 : (win_s + 2'd1);
        end else begin
          rr_d = rr_q;
        end
        if (mem_rnw_s) begin
          rd_state_d = RD_PEND;
          rd_port_d  = win_s;
        end else begin
          rd_state_d = RD_IDLE;
        end
      end else begin
        ack_d      = 4'd0;
        rd_state_d = RD_IDLE;
      end

      // Count port-0 wins that left someone else waiting.
      if (win_vld_s && (win_s == 2'd0) && (|bus.req[3:1])) begin
        scnt_d = (scnt_q >= LIM) ? LIM : (scnt_q + 4'd1);
      end else begin
        scnt_d = 4'd0;
      end
    end else begin
      ack_d = 4'd0;
      rdy_d = 4'd0;
    end
  end

  // State registers; reset drops any read still waiting for its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q      <= 4'd0;
      rdy_q      <= 4'd0;
      rddata_q   <= 16'd0;
      rr_q       <= 2'd1;
      scnt_q     <= 4'd0;
      rd_state_q <= RD_IDLE;
      rd_port_q  <= 2'd0;
    end else begin
      ack_q      <= ack_d;
      rdy_q      <= rdy_d;
      rddata_q   <= rddata_d;
      rr_q       <= rr_d;
      scnt_q     <= scnt_d;
      rd_state_q <= rd_state_d;
      rd_port_q  <= rd_port_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.rdy        = rdy_q;
  assign bus.rddata     = rddata_q;
  assign bus.mem_req    = win_vld_s;
  assign bus.mem_addr   = mem_addr_s;
  assign bus.mem_wrdata = mem_wrdata_s;
  assign bus.mem_bsel   = mem_bsel_s;
  assign bus.mem_rnw    = mem_rnw_s;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: expected ack/rdy/data pushed to a
// scoreboard before each memory-cycle strobe, popped and compared after it.
module tb_sram_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sram_arbiter_if bus_if ();

  sram_arbiter #(.STARVE_LIM(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0]  exp_ack_q[$];
  logic [3:0]  exp_rdy_q[$];
  logic [15:0] exp_dat_q[$];

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  task automatic expect_out(input logic [3:0] a, input logic [3:0] r, input logic [15:0] d);
    exp_ack_q.push_back(a);
    exp_rdy_q.push_back(r);
    exp_dat_q.push_back(d);
  endtask

  task automatic set_port(input int p, input logic rq, input logic rd, input logic [20:0] a,
                          input logic [15:0] wd, input logic [1:0] bs);
    bus_if.req[p]           = rq;
    bus_if.rnw[p]           = rd;
    bus_if.addr[21*p +: 21] = a;
    bus_if.wrdata[16*p +: 16] = wd;
    bus_if.bsel[2*p +: 2]   = bs;
  endtask

  // One cyc pulse, then check the strobes at the grant edge and their clearing one clk later.
  task automatic step(input string tag);
    logic [3:0]  ea;
    logic [3:0]  er;
    logic [15:0] ed;
    @(negedge clk);
    bus_if.cyc = 1'b1;
    @(posedge clk);
    #1;
    bus_if.cyc = 1'b0;
    if (exp_ack_q.size() > 0) begin
      ea = exp_ack_q.pop_front();
      er = exp_rdy_q.pop_front();
      ed = exp_dat_q.pop_front();
    end else begin
      ea = 4'd0;
      er = 4'd0;
      ed = 16'd0;
    end
    chk(tag, "ack", 32'(bus_if.ack), 32'(ea));
    chk(tag, "rdy", 32'(bus_if.rdy), 32'(er));
    if (er != 4'd0) begin
      chk(tag, "rddata", 32'(bus_if.rddata), 32'(ed));
    end
    @(posedge clk);
    #1;
    chk(tag, "ack_pulse", 32'(bus_if.ack), 32'd0);
    chk(tag, "rdy_pulse", 32'(bus_if.rdy), 32'd0);
  endtask

  initial begin
    bus_if.cyc        = 1'b0;
    bus_if.req        = 4'd0;
    bus_if.addr       = 84'd0;
    bus_if.wrdata     = 64'd0;
    bus_if.bsel       = 8'd0;
    bus_if.rnw        = 4'd0;
    bus_if.mem_rddata = 16'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("reset", "ack", 32'(bus_if.ack), 32'd0);
    chk("reset", "rdy", 32'(bus_if.rdy), 32'd0);
    chk("reset", "rddata", 32'(bus_if.rddata), 32'd0);
    chk("reset", "mem_req", 32'(bus_if.mem_req), 32'd0);
    chk("reset", "mem_rnw", 32'(bus_if.mem_rnw), 32'd1);
    chk("reset", "mem_addr", 32'(bus_if.mem_addr), 32'd0);
    rst_n = 1'b1;

    // Round-robin: ports 1..3 writing continuously, rr starts at 1
    set_port(1, 1'b1, 1'b0, 21'h00011, 16'h0001, 2'b11);
    set_port(2, 1'b1, 1'b0, 21'h00022, 16'h0002, 2'b11);
    set_port(3, 1'b1, 1'b0, 21'h00033, 16'h0003, 2'b11);
    for (int i = 0; i < 2; i++) begin
      expect_out(4'b0010, 4'd0, 16'd0);
      expect_out(4'b0100, 4'd0, 16'd0);
      expect_out(4'b1000, 4'd0, 16'd0);
    end
    for (int i = 0; i < 6; i++) step("rr");
    bus_if.req = 4'd0;

    // Single read on port 1
    set_port(1, 1'b1, 1'b1, 21'h01234, 16'h0000, 2'b11);
    #1;
    chk("rd1", "mem_addr", 32'(bus_if.mem_addr), 32'h01234);
    chk("rd1", "mem_rnw", 32'(bus_if.mem_rnw), 32'd1);
    chk("rd1", "mem_req", 32'(bus_if.mem_req), 32'd1);
    expect_out(4'b0010, 4'd0, 16'd0);
    step("rd1_grant");
    bus_if.req[1]     = 1'b0;
    bus_if.mem_rddata = 16'hBEEF;
    expect_out(4'd0, 4'b0010, 16'hBEEF);
    step("rd1_return");
    chk("rd1", "rddata_hold", 32'(bus_if.rddata), 32'hBEEF);

    // Starvation: ports 0 and 1 writing continuously
    set_port(0, 1'b1, 1'b0, 21'h00100, 16'h1000, 2'b11);
    set_port(1, 1'b1, 1'b0, 21'h00200, 16'h2000, 2'b11);
    #1;
    chk("starve", "prio_addr", 32'(bus_if.mem_addr), 32'h00100);
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 7; i++) begin
        expect_out(4'b0001, 4'd0, 16'd0);
        step("starve_p0");
      end
      chk("starve", "forced_addr", 32'(bus_if.mem_addr), 32'h00200);
      expect_out(4'b0010, 4'd0, 16'd0);
      step("starve_p1");
    end
    bus_if.req = 4'd0;

    // Back-to-back reads: port 2 then port 3
    set_port(2, 1'b1, 1'b1, 21'h0AAAA, 16'h0000, 2'b11);
    expect_out(4'b0100, 4'd0, 16'd0);
    step("b2b_k");
    bus_if.req[2] = 1'b0;
    set_port(3, 1'b1, 1'b1, 21'h15555, 16'h0000, 2'b11);
    bus_if.mem_rddata = 16'h1111;
    expect_out(4'b1000, 4'b0100, 16'h1111);
    step("b2b_k1");
    bus_if.req[3]     = 1'b0;
    bus_if.mem_rddata = 16'h2222;
    expect_out(4'd0, 4'b1000, 16'h2222);
    step("b2b_k2");

    // Write with byte select on port 3
    set_port(3, 1'b1, 1'b0, 21'h1F0F0, 16'hA55A, 2'b01);
    #1;
    chk("wr3", "mem_bsel", 32'(bus_if.mem_bsel), 32'h1);
    chk("wr3", "mem_rnw", 32'(bus_if.mem_rnw), 32'd0);
    chk("wr3", "mem_wrdata", 32'(bus_if.mem_wrdata), 32'hA55A);
    chk("wr3", "mem_addr", 32'(bus_if.mem_addr), 32'h1F0F0);
    expect_out(4'b1000, 4'd0, 16'd0);
    step("wr3_grant");
    bus_if.req[3] = 1'b0;
    expect_out(4'd0, 4'd0, 16'd0);
    step("wr3_norDY");

    // Reset between a read grant and its return
    set_port(1, 1'b1, 1'b1, 21'h00777, 16'h0000, 2'b11);
    expect_out(4'b0010, 4'd0, 16'd0);
    step("rst_grant");
    bus_if.req[1] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", "ack", 32'(bus_if.ack), 32'd0);
    chk("rst_mid", "rdy", 32'(bus_if.rdy), 32'd0);
    chk("rst_mid", "rddata", 32'(bus_if.rddata), 32'd0);
    chk("rst_mid", "mem_req", 32'(bus_if.mem_req), 32'd0);
    chk("rst_mid", "mem_rnw", 32'(bus_if.mem_rnw), 32'd1);
    #2;
    rst_n = 1'b1;
    bus_if.mem_rddata = 16'hDEAD;
    expect_out(4'd0, 4'd0, 16'd0);
    step("rst_no_rdy");
    // rr back at 1: with ports 1 and 2 both asking, port 1 wins
    set_port(1, 1'b1, 1'b0, 21'h00001, 16'h0000, 2'b11);
    set_port(2, 1'b1, 1'b0, 21'h00002, 16'h0000, 2'b11);
    expect_out(4'b0010, 4'd0, 16'd0);
    step("rst_rr");
    bus_if.req = 4'd0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Four-port arbiter that shares the single external-SRAM controller between on-chip masters: video fetch, CPU, DMA and TS/sprite fetch. It sits between the masters and the SRAM controller's request interface (cyc/req/addr/wrdata/bsel/rnw in, 16-bit read word out). On every memory-cycle strobe it chooses at most one master and forwards that master's request. It returns a one-clock accept strobe to that master and, for reads, the read word with a one-clock valid strobe.

## Interface
- STARVE_LIM, 7: consecutive port-0 wins allowed while any of ports 1-3 is waiting. The next grant then goes to ports 1-3. Range 1..15.
- clk  in  1  system clock; every register is clocked on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- cyc  in  1  memory-cycle strobe, one clk wide; also drives the SRAM controller's cyc.
- req  in  4  per-port request level: [0] video, [1] CPU, [2] DMA, [3] TS. Held until ack.
- addr  in  84  per-port word address, 21 bits each; port i is [21*i+20:21*i].
- wrdata  in  64  per-port write data, 16 bits each.
- bsel  in  8  per-port byte select, 2 bits each, positive.
- rnw  in  4  per-port read(1)/write(0).
- ack  out  4  one-clk pulse on the clk after the cyc on which the port was granted.
- rdy  out  4  one-clk read-data-valid pulse; at most one bit set.
- rddata  out  16  read word, valid while the matching rdy is high and held until the next rdy.
- mem_req  out  1  request to the controller.
- mem_addr  out  21  address to the controller.
- mem_wrdata  out  16  write data to the controller.
- mem_bsel  out  2  byte select to the controller.
- mem_rnw  out  1  read/~write to the controller.
- mem_rddata  in  16  read word from the controller (its registered data output).

## Operation
- Winner selection is combinational from req, the rr pointer and the starvation counter.
- Port 0 has fixed highest priority unless forced, where forced means scnt == STARVE_LIM and req[3:1] != 0.
- Ports 1-3 are served round-robin. The rr pointer names the highest-priority port among 1-3. Search order is rr, rr+1, ... with 3 wrapping to 1.
- mem_req = |req. The mem_* fields are the winner's fields. With no request, mem_rnw=1 and the other mem_* fields are 0.
- State changes happen only on a clk where cyc=1.
- On a cyc clk with a winner w:
  - set ack[w] on the next clk;
  - if w is 1..3, set rr to w+1 (3 wraps to 1);
  - record the read as pending if mem_rnw=1: rd_pend=1, rd_port=w.
- Starvation counter scnt (4 bits), updated on cyc clks:
  - w=0 while req[3:1] != 0: scnt increments;
  - winner in 1..3, or req[3:1]=0: scnt clears to 0;
  - scnt never exceeds STARVE_LIM.
- Read return:
  - At the next cyc clk after a read grant, if rd_pend=1: capture mem_rddata into rddata, pulse rdy[rd_port] on the following clk, clear rd_pend.
  - On that same cyc clk a new grant may be issued, and it may set rd_pend again. Return and new grant are both processed; neither is lost.
- Writes produce ack only, never rdy.
- A master that drops req before ack is simply not granted. A request already granted cannot be withdrawn.
- Reset values: ack=0, rdy=0, rddata=0, rr=1, scnt=0, rd_pend=0, rd_port=0. mem_* follow the combinational rule above (mem_req=|req).
- A reset mid-operation discards any pending read: no rdy is issued after rst_n is released.

## Timing
- Grant latency: 1 clk from the cyc edge to ack.
- Read latency: rdy appears 1 clk after the next cyc following the grant.
- Throughput: one access per cyc period.
- A master must hold req and all its fields stable from assertion until it sees ack. It may reassert req on the clk after ack.
- A master may issue a new read before the rdy of its previous read. Ordering is guaranteed because rdy always precedes the next grant's rdy.

## Test plan
- Single read: req=4'b0010, addr1=21'h01234, rnw=1; cyc at t0, mem_rddata=16'hBEEF before cyc at t1.
  Required: mem_addr=21'h01234 at t0; ack=4'b0010 at t0+1; rdy=4'b0010 with rddata=16'hBEEF at t1+1.
- Round-robin: ports 1, 2, 3 requesting continuously, writes, 6 cycs.
  Required grant order 1,2,3,1,2,3.
- Starvation with STARVE_LIM=7: ports 0 and 1 requesting continuously.
  Required: port 0 granted 7 times, port 1 on the 8th cyc, then the pattern repeats.
- Back-to-back reads: port 2 reads at cyc k, port 3 reads at cyc k+1, with mem_rddata 16'h1111 then 16'h2222.
  Required: rdy[2] with 16'h1111, then rdy[3] with 16'h2222, one cyc period apart.
- Write with byte select: port 3, bsel=2'b01, wrdata=16'hA55A.
  Required: mem_bsel=2'b01, mem_rnw=0, ack[3]=1, no rdy.
- Reset mid-read: pull rst_n low between grant and return, release before the next cyc.
  Required: all outputs at reset values, no rdy afterwards, rr=1.
